sprite_frame_scheduler: RTL and testbench

Frame-synchronous command scheduler between the Avalon slave and the sprite display blocks. Software posts sprite update words into a FIFO. The scheduler drains them onto the shared sprite command bus, steering every update to the back (non-displayed) ping/pong buffer. A software frame-commit request is deferred until vertical blanking starts, then issued as one flush/swap word, so sprites never tear mid-frame.

---
 rtl/sprite_cmd_pkg.sv | 34 +++
 rtl/sprite_frame_scheduler_if.sv | 23 ++
 rtl/cmd_fifo.sv | 49 ++++
 rtl/sprite_frame_scheduler.sv | 123 ++++++++++++
 tb/tb_sprite_frame_scheduler.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_cmd_pkg.sv
// rtl/sprite_cmd_pkg.sv - sprite command word layout, info codes and scheduler state
// Shared by the frame scheduler and the sprite display blocks.
package sprite_cmd_pkg;

  localparam logic [3:0] INFO_WRITE = 4'b0001;
  localparam logic [3:0] INFO_FLUSH = 4'b1111;
  localparam logic [3:0] INFO_NOP   = 4'b0000;
  localparam int         SEL_BIT    = 13;

  // Field order fixes the bit positions: sub_comp[31:26] ... msg[12:0].
  typedef struct packed {
    logic [5:0]  sub_comp;
    logic [4:0]  child;
    logic [3:0]  info;
    logic [2:0]  kind;
    logic        sel;
    logic [12:0] msg;
  } sprite_cmd_t;

  typedef enum logic [1:0] {
    ST_DRAIN,
    ST_WAIT_VB,
    ST_FLUSH
  } sched_state_t;

  function automatic sprite_cmd_t flush_word(input logic sel);
    sprite_cmd_t w;
    w      = '0;
    w.info = INFO_FLUSH;
    w.sel  = sel;
    return w;
  endfunction

endpackage

// File: rtl/sprite_frame_scheduler_if.sv
// rtl/sprite_frame_scheduler_if.sv - Avalon write side, VGA timing and sprite bus signals
// The scheduler connects through the slave modport.
interface sprite_frame_scheduler_if;

  logic        write;
  logic [31:0] writedata;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [31:0] cmd_out;
  logic        front_sel;
  logic [31:0] status;

  modport master (
    output write, writedata, hcount, vcount,
    input  cmd_out, front_sel, status
  );

  modport slave (
    input  write, writedata, hcount, vcount,
    output cmd_out, front_sel, status
  );

endinterface

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous DEPTH x 32 command FIFO with combinational read head
// Push is refused while full, judged on the pre-edge count.
module cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr_en,
  input  logic [31:0]   i_wr_data,
  input  logic          i_rd_en,
  output logic [31:0]   o_rd_data,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_push    = i_wr_en & ~o_full;
  assign w_pop     = i_rd_en & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/sprite_frame_scheduler.sv
// rtl/sprite_frame_scheduler.sv - drains sprite updates to the back buffer, swaps at vblank
// Frame commits wait in WAIT_VB so the buffer swap never lands mid-frame.
module sprite_frame_scheduler
  import sprite_cmd_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int V_ACTIVE = 480
) (
  input  logic                    clk,
  input  logic                    reset,
  sprite_frame_scheduler_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  sched_state_t r_state;
  sched_state_t w_state_next;
  sprite_cmd_t  r_cmd_out;
  logic         r_front_sel;
  logic [15:0]  r_frame_count;
  logic         r_commit_pending;
  logic         r_overflow;

  sprite_cmd_t  w_in;
  sprite_cmd_t  w_head;
  logic         w_wr_en;
  logic         w_pop;
  logic [AW:0]  w_count;
  logic         w_full;
  logic         w_empty;
  logic         w_vb_start;
  logic         w_head_flush;
  sprite_cmd_t  w_cmd_next;
  logic         w_front_sel_next;
  logic [15:0]  w_frame_count_next;
  logic         w_commit_pending_next;

  assign w_in         = bus.writedata;
  assign w_wr_en      = bus.write && (w_in.info == INFO_WRITE || w_in.info == INFO_FLUSH);
  assign w_vb_start   = (bus.vcount == 10'(V_ACTIVE)) && (bus.hcount == '0);
  assign w_head_flush = !w_empty && (w_head.info == INFO_FLUSH);

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_data (w_in),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_DRAIN;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_DRAIN:   if (w_head_flush) w_state_next = ST_WAIT_VB;
      ST_WAIT_VB: if (w_vb_start)   w_state_next = ST_FLUSH;
      ST_FLUSH:   w_state_next = ST_DRAIN;
      default:    w_state_next = ST_DRAIN;
    endcase
  end

  // The swap is registered on the vblank edge so the FLUSH word and the new
  // front_sel both appear during the single FLUSH-state cycle.
  always_comb begin
    w_pop                 = 1'b0;
    w_cmd_next            = '0;
    w_cmd_next.info       = INFO_NOP;
    w_front_sel_next      = r_front_sel;
    w_frame_count_next    = r_frame_count;
    w_commit_pending_next = r_commit_pending;
    case (r_state)
      ST_DRAIN: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head_flush) begin
            w_commit_pending_next = 1'b1;
          end else begin
            w_cmd_next     = w_head;
            w_cmd_next.sel = ~r_front_sel;
          end
        end
      end
      ST_WAIT_VB: begin
        if (w_vb_start) begin
          w_cmd_next            = flush_word(~r_front_sel);
          w_front_sel_next      = ~r_front_sel;
          w_frame_count_next    = r_frame_count + 16'd1;
          w_commit_pending_next = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cmd_out        <= '0;
      r_front_sel      <= 1'b0;
      r_frame_count    <= '0;
      r_commit_pending <= 1'b0;
      r_overflow       <= 1'b0;
    end else begin
      r_cmd_out        <= w_cmd_next;
      r_front_sel      <= w_front_sel_next;
      r_frame_count    <= w_frame_count_next;
      r_commit_pending <= w_commit_pending_next;
      if (w_wr_en && w_full) r_overflow <= 1'b1;
    end
  end

  assign bus.cmd_out   = r_cmd_out;
  assign bus.front_sel = r_front_sel;
  assign bus.status    = {r_frame_count, 6'b0, r_overflow, r_commit_pending, 2'b0, 6'(w_count)};

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// tb/tb_sprite_frame_scheduler.sv - randomized and directed checks against a queue-based model
module tb_sprite_frame_scheduler;

  localparam int DEPTH = 16;
  localparam int VACT  = 480;
  localparam logic [31:0] FLUSH_SEL1 = 32'h001E_2000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sprite_frame_scheduler_if bus ();

  sprite_frame_scheduler #(.DEPTH(DEPTH), .V_ACTIVE(VACT)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a queue of posted words plus the frame-level bookkeeping.
  logic [31:0] mq[$];
  bit          m_wait;
  bit          m_swap_cycle;
  bit          m_fs;
  bit          m_pend;
  bit          m_ovf;
  logic [15:0] m_fc;
  logic [31:0] m_cmd;

  function automatic logic [31:0] mk(input logic [3:0] info, input logic [31:0] r);
    return (r & ~(32'hF << 17)) | (32'(info) << 17);
  endfunction

  function automatic logic [64:0] mexp();
    return {m_cmd, m_fs, m_fc, 6'b0, m_ovf, m_pend, 2'b0, 6'(mq.size())};
  endfunction

  function automatic logic [64:0] dobs();
    return {bus.cmd_out, bus.front_sel, bus.status};
  endfunction

  task automatic cyc(input logic rn, input logic wr, input logic [31:0] wd,
                     input logic [9:0] h, input logic [9:0] v);
    int          n_pre;
    logic [31:0] head;
    logic [3:0]  inf;
    rst_n         = rn;
    bus.write     = wr;
    bus.writedata = wd;
    bus.hcount    = h;
    bus.vcount    = v;
    @(posedge clk);
    if (!rn) begin
      mq.delete();
      m_wait = 0; m_swap_cycle = 0; m_fs = 0; m_pend = 0; m_ovf = 0;
      m_fc = '0; m_cmd = '0;
    end else begin
      n_pre = mq.size();
      m_cmd = '0;
      if (m_swap_cycle) begin
        m_swap_cycle = 0;
      end else if (m_wait) begin
        if (v == 10'(VACT) && h == 0) begin
          m_cmd = (32'hF << 17) | (32'(!m_fs) << 13);
          m_fs = !m_fs; m_fc = m_fc + 16'd1; m_pend = 0; m_wait = 0; m_swap_cycle = 1;
        end
      end else if (n_pre > 0) begin
        head = mq.pop_front();
        if (head[20:17] == 4'hF) begin
          m_pend = 1; m_wait = 1;
        end else begin
          m_cmd = m_fs ? (head & ~32'h2000) : (head | 32'h2000);
        end
      end
      inf = wd[20:17];
      if (wr && (inf == 4'h1 || inf == 4'hF)) begin
        if (n_pre < DEPTH) mq.push_back(wd);
        else m_ovf = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, mk(4'h1, 32'h1234_5678), 0, 1);
    checks++;
    if (dobs() !== 65'b0) begin
      errors++; $display("FAIL reset_state got %h exp %h", dobs(), 65'b0);
    end
    cyc(1, 0, 0, 0, 1);
    checks++;
    if (dobs() !== mexp()) begin
      errors++; $display("FAIL reset_idle got %h exp %h", dobs(), mexp());
    end
  endtask

  task automatic test_three_writes();
    logic [31:0] w;
    w = {6'b001001, 5'b0, 4'b0001, 3'b010, 1'b0, 13'b100};
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, i < 3, w, 0, 1);
      checks++;
      if (dobs() !== mexp()) begin
        errors++; $display("FAIL three_writes cyc %0d got %h exp %h", i, dobs(), mexp());
      end
      if (i >= 1 && i <= 3) begin
        checks++;
        if (bus.cmd_out !== (w | 32'h2000) || bus.front_sel !== 1'b0) begin
          errors++; $display("FAIL three_writes_word got %h exp %h", bus.cmd_out, w | 32'h2000);
        end
      end
    end
  endtask

  task automatic test_commit();
    logic [31:0] w1, w2;
    w1 = mk(4'h1, 32'h0400_0011);
    w2 = mk(4'h1, 32'h0800_2022);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, w1, 0, 1);
    cyc(1, 1, mk(4'hF, 0), 0, 1);
    checks++;
    if (bus.cmd_out !== (w1 | 32'h2000)) begin
      errors++; $display("FAIL commit_first_write got %h exp %h", bus.cmd_out, w1 | 32'h2000);
    end
    cyc(1, 1, w2, 0, 1);
    for (int v = 470; v <= 481; v++) begin
      cyc(1, 0, 0, 0, 10'(v));
      checks++;
      if (dobs() !== mexp()) begin
        errors++; $display("FAIL commit_sweep v %0d got %h exp %h", v, dobs(), mexp());
      end
      if (v == 480) begin
        checks++;
        if (bus.cmd_out !== FLUSH_SEL1 || bus.front_sel !== 1'b1 || bus.status[31:16] !== 16'd1) begin
          errors++; $display("FAIL commit_flush got %h/%b/%h exp %h/1/0001",
                             bus.cmd_out, bus.front_sel, bus.status[31:16], FLUSH_SEL1);
        end
      end
    end
    cyc(1, 0, 0, 0, 1);
    checks++;
    if (bus.cmd_out !== (w2 & ~32'h2000)) begin
      errors++; $display("FAIL commit_second_write got %h exp %h", bus.cmd_out, w2 & ~32'h2000);
    end
  endtask

  task automatic test_bad_info();
    logic [31:0] pre;
    cyc(0, 0, 0, 0, 1);
    pre = bus.status;
    for (int i = 0; i < 3; i++) begin
      cyc(1, i == 0, mk(4'b0110, $urandom), 0, 1);
      checks++;
      if (bus.cmd_out !== 32'h0 || bus.status !== pre || dobs() !== mexp()) begin
        errors++; $display("FAIL bad_info got %h/%h exp 0/%h", bus.cmd_out, bus.status, pre);
      end
    end
  endtask

  task automatic test_overflow();
    int n_words;
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, mk(4'hF, 0), 0, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, mk(4'h1, $urandom), 0, 1);
      checks++;
      if (dobs() !== mexp()) begin
        errors++; $display("FAIL overflow_fill %0d got %h exp %h", i, dobs(), mexp());
      end
    end
    checks++;
    if (bus.status[5:0] !== 6'd16 || bus.status[9] !== 1'b1 || bus.status[8] !== 1'b1) begin
      errors++; $display("FAIL overflow_status got %h exp count 16 ovf 1 pend 1", bus.status);
    end
    cyc(1, 0, 0, 0, 10'(VACT));
    n_words = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 0, 1);
      if (bus.cmd_out[20:17] == 4'h1) n_words++;
      checks++;
      if (dobs() !== mexp()) begin
        errors++; $display("FAIL overflow_drain %0d got %h exp %h", i, dobs(), mexp());
      end
    end
    checks++;
    if (n_words != 16 || bus.status[5:0] !== 6'd0) begin
      errors++; $display("FAIL overflow_drained got %0d words exp 16", n_words);
    end
  endtask

  task automatic test_reset_mid_wait();
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, mk(4'hF, 0), 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 1, mk(4'h1, $urandom), 0, 1);
    checks++;
    if (bus.status[5:0] !== 6'd5 || bus.status[8] !== 1'b1) begin
      errors++; $display("FAIL midwait_queued got %h exp count 5 pend 1", bus.status);
    end
    cyc(0, 0, 0, 0, 1);
    checks++;
    if (dobs() !== 65'b0) begin
      errors++; $display("FAIL midwait_reset got %h exp 0", dobs());
    end
    for (int v = 478; v <= 484; v++) begin
      cyc(1, 0, 0, 0, 10'(v));
      checks++;
      if (bus.cmd_out !== 32'h0 || dobs() !== mexp()) begin
        errors++; $display("FAIL midwait_noflush v %0d got %h exp 0", v, bus.cmd_out);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [3:0]  inf;
    logic [9:0]  h, v;
    logic        rn;
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 7))
        0:       inf = 4'hF;
        1:       inf = 4'($urandom);
        default: inf = 4'h1;
      endcase
      w  = mk(inf, $urandom);
      v  = ($urandom_range(0, 3) == 0) ? 10'(VACT) : 10'($urandom_range(0, 524));
      h  = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom_range(0, 799));
      rn = ($urandom_range(0, 299) != 0);
      cyc(rn, 1'($urandom), w, h, v);
      checks++;
      if (dobs() !== mexp()) begin
        errors++; $display("FAIL random cyc %0d got %h exp %h", i, dobs(), mexp());
      end
    end
  endtask

  task automatic test_wrap();
    cyc(0, 0, 0, 0, 1);
    force dut.r_frame_count = 16'hFFFE;
    m_fc = 16'hFFFE;
    cyc(1, 0, 0, 0, 1);
    release dut.r_frame_count;
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, mk(4'hF, 0), 0, 1);
      cyc(1, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 10'(VACT));
      checks++;
      if (bus.status[31:16] !== 16'(32'hFFFE + k + 1) || bus.front_sel !== 1'(~k[0])
          || dobs() !== mexp()) begin
        errors++; $display("FAIL wrap commit %0d got fc %h sel %b exp fc %h sel %b",
                           k, bus.status[31:16], bus.front_sel, 16'(32'hFFFE + k + 1), ~k[0]);
      end
      cyc(1, 0, 0, 0, 1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.write = 0; bus.writedata = 0; bus.hcount = 0; bus.vcount = 1;
    rst_n = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_three_writes();
    test_commit();
    test_bad_info();
    test_overflow();
    test_reset_mid_wait();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
